p4_router_egress_downsizer: RTL and testbench
=============================================

P4_ROUTER_EGRESS_DOWNSIZER -- requirements
Module: p4_router_egress_downsizer

Interface
REQ-001 The block SHALL have parameter OUT_WIDTH_INDEX, default INDEX_8B, selecting the output width from the p4_router_pkg port-width enum: 8b, 16b, 32b or 64b.
REQ-002 The block SHALL have parameter DEST_WIDTH, default 8, giving the tdest width.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port sresetn, input, 1: reset, synchronous to clk and active-low.
REQ-005 Ports in_tdata/in_tkeep/in_tlast/in_tdest/in_tvalid, input, 64/8/1/DEST_WIDTH/1: the 64-bit router-core egress stream.
REQ-006 Port in_tready, output, 1: input accept.
REQ-007 Ports out_tdata/out_tkeep/out_tlast/out_tdest/out_tvalid, output, OUT_BYTES*8/OUT_BYTES/1/DEST_WIDTH/1: the egress port stream.
REQ-008 Port out_tready, input, 1: output accept.
REQ-009 Ports stat_pkt_count and stat_byte_count, output, 32 each: exist only when the stats macro is defined.

Function
REQ-010 OUT_BYTES SHALL be 1, 2, 4 or 8 for INDEX_8B..INDEX_64B; RATIO SHALL be 8/OUT_BYTES.
REQ-011 AXIS handshake: a transfer SHALL occur only on valid&&ready; out_t* SHALL hold stable while out_tvalid=1 and out_tready=0.
REQ-012 The datapath SHALL use a one-beat holding register plus a slice index idx of width clog2(RATIO), min 1.
REQ-013 States SHALL be EMPTY (no held beat) and SLICING (held beat being emitted).
REQ-014 EMPTY transitions: in_tready=1; on an input transfer, capture the beat, set idx=0 and go to SLICING.
REQ-015 Slices SHALL be emitted little-endian, with slice k = held bytes [k*OUT_BYTES +: OUT_BYTES] and out_tkeep equal to the matching tkeep bits.
REQ-016 out_tdest SHALL equal the captured in_tdest for every slice of the beat.
REQ-017 The last slice of a beat SHALL be idx=RATIO-1, or, when the held tlast=1, the highest slice with any tkeep bit set; later slices SHALL be skipped.
REQ-018 out_tlast SHALL be 1 only on the last slice of a beat whose in_tlast=1.
REQ-019 in_tready SHALL also be 1 in SLICING when the last slice is being accepted in that cycle, so a new beat loads with no bubble; otherwise 0.
REQ-020 On a last-slice accept with no new input, the block SHALL return to EMPTY.
REQ-021 Latency SHALL be one cycle from input transfer to first out_tvalid; sustained throughput SHALL be one slice per cycle.
REQ-022 For INDEX_64B the block SHALL act as a one-stage full-throughput register slice.
REQ-023 tkeep SHALL be assumed contiguous from the LSB; a non-last beat SHALL be assumed to have tkeep=8'hFF.
REQ-024 A tlast beat with tkeep=0 SHALL emit one slice with out_tkeep=0 and out_tlast=1, so packet framing is never lost.

Reset
REQ-025 While sresetn=0 the block SHALL force state=EMPTY, idx=0, out_tvalid=0, in_tready=0, out_tlast=0, and clear out_tdata/out_tkeep/out_tdest and the stats counters.
REQ-026 Reset asserted mid-packet SHALL discard the held beat; the first transfer after reset SHALL be treated as a fresh beat.

Configuration
REQ-027 When P4_ROUTER_EGR_DOWNSIZER_STATS_EN is defined, stat_pkt_count SHALL increment on each output tlast transfer.
REQ-028 When P4_ROUTER_EGR_DOWNSIZER_STATS_EN is defined, stat_byte_count SHALL add popcount(out_tkeep) per output transfer; both counters SHALL wrap modulo 2^32.
REQ-029 When P4_ROUTER_EGR_DOWNSIZER_STATS_EN is undefined, the stats ports and counters SHALL be absent and the datapath SHALL be unchanged.

Structure
REQ-030 p4_router_pkg SHALL hold the width-index-to-bytes function (get_port_bytes) and the state enum typedef egr_dsz_state_t.
REQ-031 The block SHALL be a single module with no sub-module; the per-width arrays SHALL instantiate it once per egress port.

Verification
REQ-032 INDEX_8B, one beat 0x0807060504030201, tkeep FF, tlast=1, out_tready=1: 8 transfers 01..08, tlast only on 08, in_tready low for 7 cycles.
REQ-033 INDEX_16B, tlast beat with tkeep=8'h07: 2 slices, keep 2'b11 then 2'b01, tlast on the 2nd, no further slices.
REQ-034 INDEX_32B, 3 back-to-back beats with out_tready=1: 6 consecutive output cycles, no bubbles.
REQ-035 INDEX_8B, random out_tready at 50% duty: output data stable under stall, byte order preserved, tdest constant per beat.
REQ-036 sresetn pulsed low for 1 cycle mid-beat: out_tvalid=0 the next cycle; the next packet is emitted intact from slice 0.
REQ-037 With the stats macro, 10 packets of 13 bytes at INDEX_8B: stat_pkt_count=10 and stat_byte_count=130.

Source files
------------

// File: rtl/p4_router_pkg.sv
// p4_router_pkg: shared types for the router egress path.
// Holds the egress port-width enum, the width-to-bytes mapping used to size
// per-port datapaths, and the state type of the egress downsizer.
package p4_router_pkg;

  // Egress port data-path width selector.
  typedef enum logic [1:0] {
    INDEX_8B  = 2'd0,
    INDEX_16B = 2'd1,
    INDEX_32B = 2'd2,
    INDEX_64B = 2'd3
  } port_width_idx_t;

  // Downsizer state: no beat held, or a held beat being emitted slice by slice.
  typedef enum logic {
    EMPTY   = 1'b0,
    SLICING = 1'b1
  } egr_dsz_state_t;

  // Bytes per output transfer for a given egress port width.
  function automatic int get_port_bytes(port_width_idx_t width_idx);
    case (width_idx)
      INDEX_8B:  return 1;
      INDEX_16B: return 2;
      INDEX_32B: return 4;
      default:   return 8;
    endcase
  endfunction

endpackage

// File: rtl/p4_router_egress_downsizer.sv
// Purpose:      split 64-bit router-core egress beats into OUT_BYTES-wide AXIS slices, little-endian.
// Latency:      1 cycle from input transfer to first out_tvalid; one slice per cycle sustained.
// Backpressure: in_tready only when empty or when the last slice of the held beat is accepted.
//
// Ports: clk / sresetn (synchronous, active-low); in_t* = 64-bit input stream
// with in_tready; out_t* = OUT_BYTES-wide output stream with out_tready.
// With P4_ROUTER_EGR_DOWNSIZER_STATS_EN defined, stat_pkt_count and
// stat_byte_count report output packets and valid bytes (wrap modulo 2^32).
module p4_router_egress_downsizer
  import p4_router_pkg::*;
#(
  parameter port_width_idx_t OUT_WIDTH_INDEX = INDEX_8B,
  parameter int              DEST_WIDTH      = 8,
  localparam int             OUT_BYTES       = get_port_bytes(OUT_WIDTH_INDEX),
  localparam int             RATIO           = 8 / OUT_BYTES,
  localparam int             IDX_W           = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                   clk,
  input  logic                   sresetn,
  input  logic [63:0]            in_tdata,
  input  logic [7:0]             in_tkeep,
  input  logic                   in_tlast,
  input  logic [DEST_WIDTH-1:0]  in_tdest,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [OUT_BYTES*8-1:0] out_tdata,
  output logic [OUT_BYTES-1:0]   out_tkeep,
  output logic                   out_tlast,
  output logic [DEST_WIDTH-1:0]  out_tdest,
  output logic                   out_tvalid,
`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
  output logic [31:0]            stat_pkt_count,
  output logic [31:0]            stat_byte_count,
`endif
  input  logic                   out_tready
);

  egr_dsz_state_t        state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt, last_idx;
  logic [63:0]           hold_data;
  logic [7:0]            hold_keep;
  logic                  hold_last;
  logic [DEST_WIDTH-1:0] hold_dest;
  logic                  load;
  logic                  is_last;

  // Final slice of the held beat. On a tlast beat it is the highest slice
  // carrying any valid byte; an all-zero keep still yields slice 0 so the
  // packet end is always signalled downstream.
  always_comb begin
    last_idx = IDX_W'(RATIO - 1);
    if (hold_last) begin
      last_idx = '0;
      for (int k = 1; k < RATIO; k++) begin
        if (|hold_keep[k*OUT_BYTES +: OUT_BYTES]) last_idx = IDX_W'(k);
      end
    end
  end

  assign is_last = (idx == last_idx);

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state     <= EMPTY;
      idx       <= '0;
      hold_data <= '0;
      hold_keep <= '0;
      hold_last <= 1'b0;
      hold_dest <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load) begin
        hold_data <= in_tdata;
        hold_keep <= in_tkeep;
        hold_last <= in_tlast;
        hold_dest <= in_tdest;
      end
    end
  end

  // Next-state: accepting the last slice reopens the input in the same cycle
  // so a waiting beat is loaded without a bubble.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    in_tready = 1'b0;
    case (state)
      EMPTY: begin
        in_tready = 1'b1;
        if (in_tvalid) begin
          load      = 1'b1;
          state_nxt = SLICING;
          idx_nxt   = '0;
        end
      end
      SLICING: begin
        if (out_tready) begin
          if (is_last) begin
            in_tready = 1'b1;
            idx_nxt   = '0;
            if (in_tvalid) load = 1'b1;
            else           state_nxt = EMPTY;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Reset also masks the handshake combinationally so nothing is accepted
    // during the reset cycle itself.
    if (!sresetn) begin
      in_tready = 1'b0;
      load      = 1'b0;
    end
  end

  // Output slice mux; outputs come straight from held registers, so they stay
  // stable for as long as the slice is stalled.
  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tdest  = '0;
    if (sresetn && state == SLICING) begin
      out_tvalid = 1'b1;
      out_tlast  = hold_last && is_last;
      out_tdest  = hold_dest;
      for (int k = 0; k < RATIO; k++) begin
        if (idx == IDX_W'(k)) begin
          out_tdata = hold_data[k*OUT_BYTES*8 +: OUT_BYTES*8];
          out_tkeep = hold_keep[k*OUT_BYTES +: OUT_BYTES];
        end
      end
    end
  end

`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      stat_pkt_count  <= '0;
      stat_byte_count <= '0;
    end else if (out_tvalid && out_tready) begin
      if (out_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
      stat_byte_count <= stat_byte_count + 32'($countones(out_tkeep));
    end
  end
`endif

endmodule

// File: tb/tb_p4_router_egress_downsizer.sv
// Bench for p4_router_egress_downsizer: one instance per output width, shared
// clock and reset, each lane fed from a beat queue and checked slice by slice
// against a byte-level reference model.
module tb_p4_router_egress_downsizer;
  import p4_router_pkg::*;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [7:0]  dest;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sresetn;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   rdy_pct[4];
  int   vld_pct;
  int   xfer_cnt[4];
  int   first_cyc[4];
  int   last_cyc[4];

  beat_t inq[4][$];
  beat_t expq[4][$];

  logic in_tready_a[4];
  logic out_tvalid_a[4];
  logic [31:0] spkt[4];
  logic [31:0] sbyte[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a beat carries popcount(keep) bytes (8 if not last); it leaves
  // as ceil(bytes/width) slices, at least one, tlast on the final slice.
  task automatic model_push(input int g, input beat_t b);
    int ob;
    int nb;
    int ns;
    beat_t e;
    logic [63:0] dmask;
    logic [7:0]  kmask;
    ob    = 1 << g;
    nb    = $countones(b.k);
    ns    = b.l ? (nb + ob - 1) / ob : 8 / ob;
    if (ns == 0) ns = 1;
    dmask = (ob == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (ob * 8)) - 64'd1);
    kmask = 8'((9'd1 << ob) - 9'd1);
    for (int s = 0; s < ns; s++) begin
      e.d    = (b.d >> (s * ob * 8)) & dmask;
      e.k    = (b.k >> (s * ob)) & kmask;
      e.l    = b.l && (s == ns - 1);
      e.dest = b.dest;
      expq[g].push_back(e);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int OB = 1 << g;
    logic [63:0]     in_tdata;
    logic [7:0]      in_tkeep;
    logic            in_tlast;
    logic [7:0]      in_tdest;
    logic            in_tvalid;
    logic [OB*8-1:0] out_tdata;
    logic [OB-1:0]   out_tkeep;
    logic            out_tlast;
    logic [7:0]      out_tdest;
    logic            out_tready;
    logic            fire;
    logic            stalled;
    logic [63:0]     sv_d;
    logic [63:0]     sv_c;

    p4_router_egress_downsizer #(
      .OUT_WIDTH_INDEX(port_width_idx_t'(g)),
      .DEST_WIDTH     (8)
    ) dut (
      .clk            (clk),
      .sresetn        (sresetn),
      .in_tdata       (in_tdata),
      .in_tkeep       (in_tkeep),
      .in_tlast       (in_tlast),
      .in_tdest       (in_tdest),
      .in_tvalid      (in_tvalid),
      .in_tready      (in_tready_a[g]),
      .out_tdata      (out_tdata),
      .out_tkeep      (out_tkeep),
      .out_tlast      (out_tlast),
      .out_tdest      (out_tdest),
      .out_tvalid     (out_tvalid_a[g]),
`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
      .stat_pkt_count (spkt[g]),
      .stat_byte_count(sbyte[g]),
`endif
      .out_tready     (out_tready)
    );

`ifndef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
    assign spkt[g]  = '0;
    assign sbyte[g] = '0;
`endif

    // Driver: inputs change 1 time unit after the rising edge.
    initial begin
      in_tvalid  = 1'b0;
      in_tdata   = '0;
      in_tkeep   = '0;
      in_tlast   = 1'b0;
      in_tdest   = '0;
      out_tready = 1'b0;
      fire       = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (fire) begin
          void'(inq[g].pop_front());
          fire      = 1'b0;
          in_tvalid = 1'b0;
        end
        out_tready = (int'($urandom_range(99)) < rdy_pct[g]);
        if (inq[g].size() > 0 && (in_tvalid || int'($urandom_range(99)) < vld_pct)) begin
          in_tdata  = inq[g][0].d;
          in_tkeep  = inq[g][0].k;
          in_tlast  = inq[g][0].l;
          in_tdest  = inq[g][0].dest;
          in_tvalid = 1'b1;
        end else begin
          in_tvalid = 1'b0;
        end
      end
    end

    // Monitor: samples on the falling edge.
    initial begin
      stalled = 1'b0;
      sv_d    = '0;
      sv_c    = '0;
      forever begin
        @(negedge clk);
        if (!sresetn) begin
          stalled = 1'b0;
        end else begin
          if (stalled) begin
            check($sformatf("L%0d_stall_dat", g), 64'(out_tdata), sv_d);
            check($sformatf("L%0d_stall_ctl", g),
                  64'({out_tvalid_a[g], out_tlast, 8'(out_tkeep), out_tdest}), sv_c);
          end
          if (out_tvalid_a[g] && out_tready) begin
            if (xfer_cnt[g] == 0) first_cyc[g] = cyc;
            last_cyc[g] = cyc;
            xfer_cnt[g]++;
            if (expq[g].size() == 0) begin
              check($sformatf("L%0d_unexpected_out", g), 64'(expq[g].size()), 64'd1);
            end else begin
              beat_t e;
              e = expq[g].pop_front();
              check($sformatf("L%0d_dat", g),  64'(out_tdata), e.d);
              check($sformatf("L%0d_keep", g), 64'(out_tkeep), 64'(e.k));
              check($sformatf("L%0d_last", g), 64'(out_tlast), 64'(e.l));
              check($sformatf("L%0d_dest", g), 64'(out_tdest), 64'(e.dest));
            end
          end
          stalled = out_tvalid_a[g] && !out_tready;
          sv_d    = 64'(out_tdata);
          sv_c    = 64'({out_tvalid_a[g], out_tlast, 8'(out_tkeep), out_tdest});
          if (in_tvalid && in_tready_a[g]) begin
            model_push(g, {in_tdata, in_tkeep, in_tlast, in_tdest});
            fire = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_pkt(input int g, input int nbytes, input logic [7:0] dest);
    int rem;
    beat_t b;
    rem = nbytes;
    do begin
      b.d    = {$urandom, $urandom};
      b.dest = dest;
      if (rem > 8) begin
        b.k = 8'hFF;
        b.l = 1'b0;
        rem -= 8;
      end else begin
        b.k = 8'((9'd1 << rem) - 9'd1);
        b.l = 1'b1;
        rem = 0;
      end
      inq[g].push_back(b);
    end while (!b.l);
  endtask

  task automatic clear_xfer();
    for (int j = 0; j < 4; j++) xfer_cnt[j] = 0;
  endtask

  task automatic wait_idle(input int budget);
    int pend;
    for (int i = 0; i < budget; i++) begin
      pend = 0;
      for (int j = 0; j < 4; j++) pend += inq[j].size() + expq[j].size();
      if (pend == 0) break;
      tick();
    end
    pend = 0;
    for (int j = 0; j < 4; j++) pend += inq[j].size() + expq[j].size();
    check("drain", 64'(pend), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lowcnt;
    sresetn = 1'b0;
    vld_pct = 100;
    for (int j = 0; j < 4; j++) begin
      rdy_pct[j]   = 100;
      xfer_cnt[j]  = 0;
      first_cyc[j] = 0;
      last_cyc[j]  = 0;
    end
    repeat (3) @(posedge clk);
    tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rst_in_tready_L%0d", j), 64'(in_tready_a[j]), 64'd0);
      check($sformatf("rst_out_tvalid_L%0d", j), 64'(out_tvalid_a[j]), 64'd0);
    end
`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
    check("rst_stat_pkt", 64'(spkt[0]), 64'd0);
    check("rst_stat_byte", 64'(sbyte[0]), 64'd0);
`endif
    @(posedge clk);
    #2;
    sresetn = 1'b1;
    tick();

    // 8-bit port, one full tlast beat: 8 slices, input closed for 7 cycles.
    clear_xfer();
    inq[0].push_back(beat_t'{d: 64'h0807060504030201, k: 8'hFF, l: 1'b1, dest: 8'h5A});
    for (int i = 0; i < 20 && expq[0].size() == 0; i++) tick();
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_tready_a[0]) break;
      lowcnt++;
    end
    check("8b_in_tready_low_cycles", 64'(lowcnt), 64'd7);
    wait_idle(100);
    check("8b_slices", 64'(xfer_cnt[0]), 64'd8);

    // 16-bit port, tlast beat with three valid bytes: two slices only.
    clear_xfer();
    inq[1].push_back(beat_t'{d: {$urandom, $urandom}, k: 8'h07, l: 1'b1, dest: 8'h11});
    wait_idle(100);
    check("16b_partial_slices", 64'(xfer_cnt[1]), 64'd2);

    // Empty tlast beat on every width: exactly one framing slice.
    clear_xfer();
    for (int j = 0; j < 4; j++)
      inq[j].push_back(beat_t'{d: {$urandom, $urandom}, k: 8'h00, l: 1'b1, dest: 8'(j)});
    wait_idle(100);
    for (int j = 0; j < 4; j++)
      check($sformatf("zero_keep_slices_L%0d", j), 64'(xfer_cnt[j]), 64'd1);

    // Back-to-back beats: 32-bit port and 64-bit register-slice mode, no bubbles.
    clear_xfer();
    send_pkt(2, 24, 8'h22);
    send_pkt(3, 32, 8'h33);
    wait_idle(200);
    check("32b_b2b_slices", 64'(xfer_cnt[2]), 64'd6);
    check("32b_b2b_span", 64'(last_cyc[2] - first_cyc[2]), 64'd5);
    check("64b_b2b_beats", 64'(xfer_cnt[3]), 64'd4);
    check("64b_b2b_span", 64'(last_cyc[3] - first_cyc[3]), 64'd3);

    // Random traffic with 50% output backpressure on every width.
    vld_pct = 70;
    for (int j = 0; j < 4; j++) rdy_pct[j] = 50;
    for (int j = 0; j < 4; j++)
      for (int p = 0; p < 25; p++)
        send_pkt(j, int'($urandom_range(40)), 8'($urandom));
    wait_idle(20000);

    // Reset pulse in the middle of a beat, then fresh packets.
    vld_pct = 100;
    for (int j = 0; j < 4; j++) rdy_pct[j] = 100;
    send_pkt(0, 16, 8'h44);
    for (int i = 0; i < 20 && expq[0].size() == 0; i++) tick();
    tick();
    tick();
    @(posedge clk);
    #2;
    sresetn = 1'b0;
    for (int j = 0; j < 4; j++) begin
      inq[j].delete();
      expq[j].delete();
    end
    tick();
    check("midrst_in_tready", 64'(in_tready_a[0]), 64'd0);
    check("midrst_out_tvalid", 64'(out_tvalid_a[0]), 64'd0);
    @(posedge clk);
    #2;
    sresetn = 1'b1;
    tick();
    check("postrst_out_tvalid", 64'(out_tvalid_a[0]), 64'd0);

    clear_xfer();
    for (int p = 0; p < 10; p++) send_pkt(0, 13, 8'h55);
    wait_idle(2000);
    check("postrst_slices", 64'(xfer_cnt[0]), 64'd130);
`ifdef P4_ROUTER_EGR_DOWNSIZER_STATS_EN
    check("stat_pkt_count", 64'(spkt[0]), 64'd10);
    check("stat_byte_count", 64'(sbyte[0]), 64'd130);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
